// File: rtl/fifo_wr_arbiter_ctrl_if.sv
// Handshake/bus bundle between the FIFO write arbiter controller, its two producers,
// the consumer read port and the FIFO register file.
interface fifo_wr_arbiter_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  logic              wr_req0;
  logic              wr_req1;
  logic [DATA_W-1:0] wr_data0;
  logic [DATA_W-1:0] wr_data1;
  logic              rd_en;
  logic [2:0]        state;
  logic              we;
  logic              re;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] mem_din;
  logic [1:0]        grant;
  logic              wr_err;
  logic              rd_err;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   data_count;

  modport slave (
    input  wr_req0, wr_req1, wr_data0, wr_data1, rd_en,
    output state, we, re, wr_addr, rd_addr, mem_din, grant,
    output wr_err, rd_err, full, empty, data_count
  );

  modport master (
    output wr_req0, wr_req1, wr_data0, wr_data1, rd_en,
    input  state, we, re, wr_addr, rd_addr, mem_din, grant,
    input  wr_err, rd_err, full, empty, data_count
  );
endinterface

// File: rtl/fifo_wr_arbiter_ctrl.sv
// Round-robin write arbiter + read sequencer for an 8-entry FIFO register file; reads beat writes.
// Requests sampled at edge N, memory controls registered for edge N+1; full stalls writers via wr_err.
module fifo_wr_arbiter_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_wr_arbiter_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    ST_INIT     = 3'b000,
    ST_WRITE    = 3'b001,
    ST_WR_ERROR = 3'b010,
    ST_READ     = 3'b011,
    ST_RD_ERROR = 3'b100,
    ST_NO_OP    = 3'b101
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   head_q, head_d;
  logic [ADDR_W-1:0]   tail_q, tail_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                rr_q, rr_d;
  logic                we_q, we_d;
  logic                re_q, re_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]   mem_din_q, mem_din_d;
  logic [1:0]          grant_q, grant_d;
  logic                wr_err_q, wr_err_d;
  logic                rd_err_q, rd_err_d;

  logic full_w, empty_w, wr_any, rd_ok, pick;

  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);
  assign wr_any  = bus.wr_req0 | bus.wr_req1;
  assign rd_ok   = bus.rd_en & ~empty_w;
  // rr_q names the favoured producer; it only matters when both request.
  assign pick    = (bus.wr_req0 & bus.wr_req1) ? rr_q : bus.wr_req1;

  always_comb begin
    state_d   = ST_NO_OP;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    rr_d      = rr_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    mem_din_d = mem_din_q;
    grant_d   = 2'b00;
    wr_err_d  = 1'b0;
    rd_err_d  = bus.rd_en & empty_w;

    if (rd_ok) begin
      state_d   = ST_READ;
      re_d      = 1'b1;
      rd_addr_d = head_q;
      head_d    = head_q + PTR_ONE;
      count_d   = count_q - CNT_ONE;
    end else if (wr_any && !full_w) begin
      state_d   = ST_WRITE;
      we_d      = 1'b1;
      wr_addr_d = tail_q;
      mem_din_d = pick ? bus.wr_data1 : bus.wr_data0;
      grant_d   = pick ? 2'b10 : 2'b01;
      tail_d    = tail_q + PTR_ONE;
      count_d   = count_q + CNT_ONE;
      rr_d      = ~pick;
    end else if (bus.rd_en) begin
      state_d = ST_RD_ERROR;
    end else if (wr_any) begin
      state_d  = ST_WR_ERROR;
      wr_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_INIT;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      rr_q      <= 1'b0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      mem_din_q <= '0;
      grant_q   <= 2'b00;
      wr_err_q  <= 1'b0;
      rd_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      rr_q      <= rr_d;
      we_q      <= we_d;
      re_q      <= re_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      mem_din_q <= mem_din_d;
      grant_q   <= grant_d;
      wr_err_q  <= wr_err_d;
      rd_err_q  <= rd_err_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.we         = we_q;
  assign bus.re         = re_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.mem_din    = mem_din_q;
  assign bus.grant      = grant_q;
  assign bus.wr_err     = wr_err_q;
  assign bus.rd_err     = rd_err_q;
  assign bus.full       = full_w;
  assign bus.empty      = empty_w;
  assign bus.data_count = count_q;
endmodule

// File: tb/tb_fifo_wr_arbiter_ctrl.sv
// Directed scenarios followed by random traffic, each cycle compared against a queue-based FIFO model.
module tb_fifo_wr_arbiter_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  fifo_wr_arbiter_ctrl_if #(.DATA_W(32), .ADDR_W(3)) bus ();

  fifo_wr_arbiter_ctrl #(.DATA_W(32), .ADDR_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mq[$];
  logic [31:0] mem [8];
  int m_head, m_tail, m_rr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit r0, input bit r1, input logic [31:0] d0,
                       input logic [31:0] d1, input bit rd);
    bus.wr_req0  = r0;
    bus.wr_req1  = r1;
    bus.wr_data0 = d0;
    bus.wr_data1 = d1;
    bus.rd_en    = rd;
  endtask

  // Reset is applied with live requests to show that it overrides them.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b1, $urandom, $urandom, 1'b1);
    @(posedge clk);
    #1;
    mq.delete();
    m_head = 0; m_tail = 0; m_rr = 0;
    chk("rst_state", bus.state, 3'b000);
    chk("rst_we", bus.we, 0);
    chk("rst_re", bus.re, 0);
    chk("rst_grant", bus.grant, 0);
    chk("rst_wr_err", bus.wr_err, 0);
    chk("rst_rd_err", bus.rd_err, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_mem_din", bus.mem_din, 0);
    chk("rst_count", bus.data_count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic step(input bit r0, input bit r1, input logic [31:0] d0,
                      input logic [31:0] d1, input bit rd);
    int cnt, g;
    int e_state, e_grant;
    bit e_we, e_re, e_wr_err, e_rd_err;
    int e_waddr, e_raddr;
    logic [31:0] e_din, e_rdata;
    @(negedge clk);
    drive(r0, r1, d0, d1, rd);
    @(posedge clk);
    #1;
    cnt = mq.size();
    e_we = 0; e_re = 0; e_grant = 0; e_waddr = 0; e_raddr = 0; e_din = 0; e_rdata = 0;
    e_rd_err = rd && cnt == 0;
    e_wr_err = 0;
    if (rd && cnt > 0) begin
      e_state = 3; e_re = 1; e_raddr = m_head;
      m_head = (m_head + 1) % 8;
      e_rdata = mq.pop_front();
    end else if ((r0 || r1) && cnt < 8) begin
      g = (r0 && r1) ? m_rr : (r1 ? 1 : 0);
      e_state = 1; e_we = 1; e_waddr = m_tail;
      e_din = g ? d1 : d0;
      e_grant = 1 << g;
      mq.push_back(e_din);
      m_tail = (m_tail + 1) % 8;
      m_rr = 1 - g;
    end else if (rd) begin
      e_state = 4;
    end else if (r0 || r1) begin
      e_state = 2; e_wr_err = 1;
    end else begin
      e_state = 5;
    end
    chk("state", bus.state, e_state);
    chk("we", bus.we, e_we);
    chk("re", bus.re, e_re);
    chk("grant", bus.grant, e_grant);
    chk("wr_err", bus.wr_err, e_wr_err);
    chk("rd_err", bus.rd_err, e_rd_err);
    chk("count", bus.data_count, mq.size());
    chk("full", bus.full, mq.size() == 8);
    chk("empty", bus.empty, mq.size() == 0);
    if (e_we) begin
      chk("wr_addr", bus.wr_addr, e_waddr);
      chk("mem_din", bus.mem_din, e_din);
      mem[bus.wr_addr] = bus.mem_din;
    end
    if (e_re) begin
      chk("rd_addr", bus.rd_addr, e_raddr);
      chk("rd_data", mem[bus.rd_addr], e_rdata);
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) mem[i] = 32'h0;

    // single producer write from reset
    do_reset();
    step(1, 0, 32'hA5, 32'h0, 0);

    // both producers hammering until full, then one rejected request
    do_reset();
    for (int i = 0; i < 9; i++) step(1, 1, $urandom, $urandom, 0);

    // read wins over a write while full, then tail wraps to 0
    step(0, 1, 32'h0, 32'h1111_2222, 1);
    step(0, 1, 32'h0, 32'h3333_4444, 0);

    // read on empty, alone and alongside a write
    do_reset();
    step(0, 0, 32'h0, 32'h0, 1);
    step(1, 0, 32'hDEAD_BEEF, 32'h0, 1);

    // write/read pairs wrapping both pointers
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(i % 2 == 0, i % 2 == 1, $urandom, $urandom, 0);
      step(0, 0, 32'h0, 32'h0, 1);
    end
    step(0, 0, 32'h0, 32'h0, 0);

    // reset mid-burst
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 1, $urandom, $urandom, 0);
    do_reset();

    // random traffic: write-heavy phase then read-heavy phase
    for (int i = 0; i < 400; i++) begin
      bit r0, r1, rd;
      r0 = ($urandom_range(0, 99) < ((i < 200) ? 70 : 30));
      r1 = ($urandom_range(0, 99) < ((i < 200) ? 70 : 30));
      rd = ($urandom_range(0, 99) < ((i < 200) ? 25 : 65));
      step(r0, r1, $urandom, $urandom, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
